// File: rtl/nonogram_frame_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nonogram_frame_parser                                                       |
// | Parses framed nonogram clue streams from the UART into the clue RAM.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module nonogram_frame_parser #(
   parameter int          MAX_DIM        = 15,
   parameter int          MAX_CLUES      = 8,
   parameter int          TIMEOUT_CYCLES = 5_000_000,
   parameter logic [7:0]  SOF_BYTE       = 8'hAA,
   localparam int         ADDR_W         = $clog2(2*MAX_DIM*(MAX_CLUES+1))
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              axiiv,
   input  logic [7:0]        axiid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [3:0]        rows,
   output logic [3:0]        cols,
   output logic              puzzle_valid,
   output logic              frame_done,
   output logic              frame_err,
   output logic [2:0]        err_code,
   output logic              busy
);

   localparam int STRIDE = MAX_CLUES + 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ROWS = 3'd1,
      S_COLS = 3'd2,
      S_LEN  = 3'd3,
      S_CLUE = 3'd4,
      S_CHK  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        chk_q, chk_d;
   logic [7:0]        line_q, line_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        idx_q, idx_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [3:0]        rows_q, rows_d;
   logic [3:0]        cols_q, cols_d;
   logic              pv_q, pv_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [2:0]        err_code_q, err_code_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;

   logic [7:0]        last_line_idx;
   logic              last_line;
   logic [7:0]        clue_max;
   logic [ADDR_W-1:0] line_base;
   logic              dim_bad;

   assign last_line_idx = {4'd0, rows_q} + {4'd0, cols_q} - 8'd1;
   assign last_line     = (line_q == last_line_idx);
   // Row clues are bounded by the column count and vice versa.
   assign clue_max      = (line_q < {4'd0, rows_q}) ? {4'd0, cols_q} : {4'd0, rows_q};
   assign line_base     = ADDR_W'(line_q) * ADDR_W'(STRIDE);
   assign dim_bad       = (axiid == 8'd0) || (axiid > 8'(MAX_DIM));

   always_comb begin
      state_d    = state_q;
      chk_d      = chk_q;
      line_d     = line_q;
      len_d      = len_q;
      idx_d      = idx_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      pv_d       = pv_q;
      err_code_d = err_code_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_en_d    = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      tmo_d      = (state_q == S_IDLE || axiiv) ? '0 : tmo_q + 1'b1;

      if (state_q != S_IDLE && !axiiv && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         state_d    = S_IDLE;
         err_d      = 1'b1;
         err_code_d = 3'd5;
         tmo_d      = '0;
      end else if (axiiv) begin
         if (state_q != S_IDLE) chk_d = chk_q ^ axiid;
         case (state_q)
            S_IDLE: begin
               if (axiid == SOF_BYTE) begin
                  state_d    = S_ROWS;
                  chk_d      = 8'd0;
                  pv_d       = 1'b0;
                  err_code_d = 3'd0;
                  line_d     = 8'd0;
               end
            end
            S_ROWS: begin
               if (dim_bad) begin
                  state_d    = S_IDLE;
                  err_d      = 1'b1;
                  err_code_d = 3'd1;
               end else begin
                  rows_d  = axiid[3:0];
                  state_d = S_COLS;
               end
            end
            S_COLS: begin
               if (dim_bad) begin
                  state_d    = S_IDLE;
                  err_d      = 1'b1;
                  err_code_d = 3'd1;
               end else begin
                  cols_d  = axiid[3:0];
                  line_d  = 8'd0;
                  state_d = S_LEN;
               end
            end
            S_LEN: begin
               if (axiid > 8'(MAX_CLUES)) begin
                  state_d    = S_IDLE;
                  err_d      = 1'b1;
                  err_code_d = 3'd2;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = line_base;
                  wr_data_d = axiid;
                  len_d     = axiid;
                  idx_d     = 8'd0;
                  if (axiid != 8'd0)  state_d = S_CLUE;
                  else if (last_line) state_d = S_CHK;
                  else                line_d  = line_q + 8'd1;
               end
            end
            S_CLUE: begin
               if (axiid == 8'd0 || axiid > clue_max) begin
                  state_d    = S_IDLE;
                  err_d      = 1'b1;
                  err_code_d = 3'd3;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = line_base + ADDR_W'(idx_q) + ADDR_W'(1);
                  wr_data_d = axiid;
                  if (idx_q == len_q - 8'd1) begin
                     if (last_line) begin
                        state_d = S_CHK;
                     end else begin
                        state_d = S_LEN;
                        line_d  = line_q + 8'd1;
                     end
                  end else begin
                     idx_d = idx_q + 8'd1;
                  end
               end
            end
            S_CHK: begin
               state_d = S_IDLE;
               if (axiid == chk_q) begin
                  done_d = 1'b1;
                  pv_d   = 1'b1;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 3'd4;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         chk_q      <= 8'd0;
         line_q     <= 8'd0;
         len_q      <= 8'd0;
         idx_q      <= 8'd0;
         tmo_q      <= '0;
         rows_q     <= 4'd0;
         cols_q     <= 4'd0;
         pv_q       <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 3'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         chk_q      <= chk_d;
         line_q     <= line_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         pv_q       <= pv_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign rows         = rows_q;
   assign cols         = cols_q;
   assign puzzle_valid = pv_q;
   assign frame_done   = done_q;
   assign frame_err    = err_q;
   assign err_code     = err_code_q;
   assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nonogram_frame_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nonogram_frame_parser                                                    |
// | Frame-level bench: puzzles are built as clue lists, then serialised.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_nonogram_frame_parser;

   localparam int MAX_DIM   = 15;
   localparam int MAX_CLUES = 8;
   localparam int STRIDE    = MAX_CLUES + 1;
   localparam int TMO       = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       axiiv;
   logic [7:0] axiid;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] rows, cols;
   logic       puzzle_valid, frame_done, frame_err, busy;
   logic [2:0] err_code;

   nonogram_frame_parser #(
      .MAX_DIM(MAX_DIM), .MAX_CLUES(MAX_CLUES), .TIMEOUT_CYCLES(TMO), .SOF_BYTE(8'hAA)
   ) dut (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rows(rows), .cols(cols), .puzzle_valid(puzzle_valid),
      .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int idx; int addr; int data;} wr_t;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] tx[$];
   wr_t        exp_wr[$];
   int         exp_kind;
   int         g_r, g_c;
   int         g_len[30];
   int         g_clue[30][8];
   int         len_idx[30];
   int         clue_idx[30][8];

   int cap_addr[$];
   int cap_data[$];
   int done_cnt = 0;
   int err_cnt  = 0;

   always @(negedge clk) begin
      if (wr_en) begin
         cap_addr.push_back(int'(wr_addr));
         cap_data.push_back(int'(wr_data));
      end
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      axiiv = 1'b1;
      axiid = b;
      @(negedge clk);
      axiiv = 1'b0;
      axiid = 8'($urandom);
   endtask

   // Serialise the puzzle held in g_* and list every RAM write it should cause.
   task automatic build_frame();
      logic [7:0] c;
      tx.delete();
      exp_wr.delete();
      tx.push_back(8'hAA);
      tx.push_back(8'(g_r));
      tx.push_back(8'(g_c));
      for (int ln = 0; ln < g_r + g_c; ln++) begin
         len_idx[ln] = tx.size();
         exp_wr.push_back('{tx.size(), ln*STRIDE, g_len[ln]});
         tx.push_back(8'(g_len[ln]));
         for (int k = 0; k < g_len[ln]; k++) begin
            clue_idx[ln][k] = tx.size();
            exp_wr.push_back('{tx.size(), ln*STRIDE + 1 + k, g_clue[ln][k]});
            tx.push_back(8'(g_clue[ln][k]));
         end
      end
      c = 8'd0;
      for (int i = 1; i < tx.size(); i++) c = c ^ tx[i];
      tx.push_back(c);
      exp_kind = 0;
   endtask

   task automatic cut(input int keep, input int wr_lim, input int kind);
      wr_t kept[$];
      tx = tx[0:keep-1];
      foreach (exp_wr[i]) if (exp_wr[i].idx < wr_lim) kept.push_back(exp_wr[i]);
      exp_wr   = kept;
      exp_kind = kind;
   endtask

   task automatic rand_puzzle();
      g_r = $urandom_range(1, MAX_DIM);
      g_c = $urandom_range(1, MAX_DIM);
      for (int ln = 0; ln < g_r + g_c; ln++) begin
         g_len[ln] = $urandom_range(0, MAX_CLUES);
         for (int k = 0; k < MAX_CLUES; k++)
            g_clue[ln][k] = $urandom_range(1, (ln < g_r) ? g_c : g_r);
      end
   endtask

   task automatic set_2x2();
      g_r = 2; g_c = 2;
      for (int ln = 0; ln < 4; ln++) g_len[ln] = 1;
      g_clue[0][0] = 2; g_clue[1][0] = 1; g_clue[2][0] = 2; g_clue[3][0] = 1;
   endtask

   task automatic run_frame(input string tag);
      int wb, d0, e0, n;
      wb = cap_addr.size();
      d0 = done_cnt;
      e0 = err_cnt;
      foreach (tx[i]) begin
         send_byte(tx[i]);
         if (i < tx.size() - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (exp_kind == 5) begin
         repeat (TMO - 1) @(negedge clk);
         check({tag, ":tmo_early"}, 32'(frame_err), 32'd0);
         @(negedge clk);
         check({tag, ":tmo_pulse"}, 32'(frame_err), 32'd1);
         repeat (2) @(negedge clk);
      end else begin
         repeat (3) @(negedge clk);
      end
      n = cap_addr.size() - wb;
      check({tag, ":wr_count"}, 32'(n), 32'(exp_wr.size()));
      for (int i = 0; i < n && i < exp_wr.size(); i++) begin
         check({tag, ":wr_addr"}, 32'(cap_addr[wb+i]), 32'(exp_wr[i].addr));
         check({tag, ":wr_data"}, 32'(cap_data[wb+i]), 32'(exp_wr[i].data));
      end
      check({tag, ":done_pulses"}, 32'(done_cnt - d0), (exp_kind == 0) ? 32'd1 : 32'd0);
      check({tag, ":err_pulses"},  32'(err_cnt - e0),  (exp_kind == 0) ? 32'd0 : 32'd1);
      check({tag, ":err_code"},    32'(err_code),      32'(exp_kind));
      check({tag, ":puzzle_valid"}, 32'(puzzle_valid), (exp_kind == 0) ? 32'd1 : 32'd0);
      check({tag, ":busy"},        32'(busy),          32'd0);
      if (exp_kind == 0) begin
         check({tag, ":rows"}, 32'(rows), 32'(g_r));
         check({tag, ":cols"}, 32'(cols), 32'(g_c));
      end
   endtask

   initial begin
      int mode, f, ln, k, bound, e0;
      axiiv = 1'b0;
      axiid = 8'd0;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_a", {wr_en, wr_addr, wr_data, rows, cols}, 32'd0);
      check("reset_b", {puzzle_valid, frame_done, frame_err, err_code, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      set_2x2(); build_frame(); run_frame("good2x2");

      set_2x2(); build_frame(); tx[tx.size()-1] = 8'h5A; exp_kind = 4; run_frame("badchk");

      tx = {8'hAA, 8'h10, 8'h05}; exp_wr.delete(); exp_kind = 1; run_frame("baddim");

      set_2x2(); build_frame(); f = clue_idx[0][0]; tx[f] = 8'h03; cut(f + 1, f, 3);
      run_frame("badclue");

      set_2x2(); build_frame(); f = len_idx[0]; tx[f] = 8'h09; cut(f + 1, f, 2);
      run_frame("badlen");

      g_r = 3; g_c = 3; for (int i = 0; i < 6; i++) begin g_len[i] = 1; g_clue[i][0] = 1; end
      build_frame(); cut(4, 4, 5); run_frame("timeout");

      set_2x2(); build_frame(); run_frame("good_after_tmo");

      for (int it = 0; it < 24; it++) begin
         mode = $urandom_range(0, 5);
         rand_puzzle();
         ln = $urandom_range(0, g_r + g_c - 1);
         if (mode == 4 && g_len[ln] == 0) g_len[ln] = 1;
         build_frame();
         case (mode)
            1: begin
               tx[tx.size()-1] = tx[tx.size()-1] ^ 8'($urandom_range(1, 255));
               exp_kind = 4;
            end
            2: begin
               f = $urandom_range(1, 2);
               tx[f] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_DIM + 1, 255));
               cut(f + 1, f, 1);
            end
            3: begin
               f = len_idx[ln];
               tx[f] = 8'($urandom_range(MAX_CLUES + 1, 255));
               cut(f + 1, f, 2);
            end
            4: begin
               k = $urandom_range(0, g_len[ln] - 1);
               f = clue_idx[ln][k];
               bound = (ln < g_r) ? g_c : g_r;
               tx[f] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(bound + 1, 255));
               cut(f + 1, f, 3);
            end
            5: begin
               f = $urandom_range(1, tx.size() - 1);
               cut(f, f, 5);
            end
            default: ;
         endcase
         if (mode >= 1 && mode <= 4)
            repeat ($urandom_range(0, 2)) tx.push_back(8'($urandom_range(0, 127)));
         run_frame($sformatf("rand%0d_m%0d", it, mode));
      end

      // Abandon a frame mid-clue with reset.
      e0 = err_cnt;
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h02); send_byte(8'h02); send_byte(8'h01);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_a", {wr_en, wr_addr, wr_data, rows, cols}, 32'd0);
      check("midrst_b", {puzzle_valid, frame_done, frame_err, err_code, busy}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
      g_r = 1; g_c = 1; g_len[0] = 1; g_len[1] = 1; g_clue[0][0] = 1; g_clue[1][0] = 1;
      build_frame();
      check("good1x1_chk_byte", 32'(tx[tx.size()-1]), 32'd0);
      run_frame("good1x1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nonogram_frame_parser.md
Name: nonogram_frame_parser

Overview:
Consumes the byte stream produced by the UART receiver (one-cycle valid strobe plus byte) and parses a framed nonogram puzzle description. Validates the frame, writes each line's clue count and clues into a clue RAM through a single write port, and reports puzzle dimensions plus a done/error pulse to the solver control logic. Sits between the UART receiver and the clue memory and solver.

Parameters:
MAX_DIM, 15, maximum rows and maximum columns accepted.
MAX_CLUES, 8, maximum clues per line; line stride in the RAM is MAX_CLUES+1.
TIMEOUT_CYCLES, 5_000_000, maximum idle gap between bytes inside a frame (100 ms at 50 MHz).
SOF_BYTE, 8'hAA, start-of-frame marker.
ADDR_W (localparam), $clog2(2*MAX_DIM*(MAX_CLUES+1)), RAM address width (9 at defaults).

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
axiiv  in  1  byte valid, single-cycle strobe from the UART receiver
axiid  in  8  received byte, sampled only when axiiv=1
wr_en  out  1  clue RAM write strobe
wr_addr  out  ADDR_W  clue RAM address
wr_data  out  8  clue RAM write data
rows  out  4  latched row count
cols  out  4  latched column count
puzzle_valid  out  1  high while the most recent frame completed without error
frame_done  out  1  one-cycle pulse on a good frame
frame_err  out  1  one-cycle pulse on frame abort
err_code  out  3  abort cause, held until the next abort or a new SOF
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, checksum 0, timeout counter 0. Reset mid-frame abandons the frame with no err pulse.
- Frame format: SOF, R, C, then R+C line records, then CHK. Each line record is L followed by L clue bytes. Lines 0..R-1 are rows; lines R..R+C-1 are columns.
- CHK equals the XOR of every byte after SOF, up to but not including CHK.
- States and transitions:
  - IDLE: a byte equal to SOF clears the checksum and puzzle_valid and moves to ROWS. Other bytes are ignored.
  - ROWS: latch R, then go to COLS.
  - COLS: latch C, then go to LEN.
  - LEN: accept L.
  - CLUE: accept L clue bytes.
  - CHK: compare the byte against the checksum.
  - Every valid byte advances at most one step. Bytes never arrive on consecutive cycles, but back-to-back strobes must still work.
- RAM writes are registered: wr_en asserts exactly one cycle after the axiiv that carries the byte, for one cycle.
  - LEN write: addr = line*(MAX_CLUES+1), data = L.
  - Clue k (0-based) write: addr = line*(MAX_CLUES+1)+1+k, data = clue.
  - L=0 writes count 0 and advances directly to the next line (or to CHK after the last line).
- Validation (abort on the offending byte):
  - R or C equal to 0 or greater than MAX_DIM: err 1.
  - L greater than MAX_CLUES: err 2, with no write for that byte.
  - A clue equal to 0, or greater than C for a row line or greater than R for a column line: err 3, with no write.
  - Checksum mismatch: err 4.
  - Timeout: err 5.
- Abort: frame_err pulses one cycle after the byte (or timeout), err_code is set, state returns to IDLE. Prior RAM writes are not undone. rows/cols keep their latched values and puzzle_valid stays 0.
- Timeout: the counter clears on every axiiv and increments in non-IDLE states. Reaching TIMEOUT_CYCLES-1 aborts with err 5. The counter is held at 0 in IDLE.
- CHK match: frame_done pulses one cycle after the CHK strobe and puzzle_valid is set the same cycle.
- An SOF byte mid-frame is treated as ordinary data, not a restart.
- Checksum and line index arithmetic are 8-bit and modular. The line index never exceeds 2*MAX_DIM-1.

Test Plan:
1. Good 2x2 frame AA 02 02 01 02 01 01 01 02 01 01 00 -> writes (0,1)(1,2)(9,1)(10,1)(18,1)(19,2)(27,1)(28,1); frame_done pulse; rows=2, cols=2, puzzle_valid=1.
2. Same frame with CHK=0x5A -> all 8 writes occur; frame_err pulse with err_code=4; puzzle_valid=0; busy returns to 0.
3. AA 10 05 -> frame_err with err_code=1 immediately after byte 0x10; no writes; subsequent bytes ignored until the next AA.
4. 2x2 frame with row0 record 01 03 -> count write to addr 0, then err_code=3 on byte 03 with no write to addr 1. Separately, record 09 -> err_code=2.
5. Send AA 03 03 01, then no bytes for TIMEOUT_CYCLES (use a small parameter, e.g. 100) -> frame_err with err_code=5 after exactly 100 idle cycles. Then a good frame completes normally.
6. Assert rst mid-CLUE -> next cycle all outputs 0 and state IDLE; no err pulse; a following good 1x1 frame AA 01 01 01 01 01 01 00 passes.
